// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters; ports: clk, reset (sync active-low), lookup_pc/lookup_opcode -> take_branch/branch_predict, update_* learn port, predict_count/mispredict_count stats (built only with BP_STATS_EN)
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef OP_CODE_BITS
`define OP_CODE_BITS 6
`endif
`ifndef OP_CODE_JMP
`define OP_CODE_JMP 6'b110000
`endif
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int INDEX_BITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [`ADDR_WIDTH-1:0]   lookup_pc,
  input  logic [`OP_CODE_BITS-1:0] lookup_opcode,
  output logic                     take_branch,
  output logic [`ADDR_WIDTH-1:0]   branch_predict,
  input  logic                     update_valid,
  input  logic [`ADDR_WIDTH-1:0]   update_pc,
  input  logic                     update_taken,
  input  logic [`ADDR_WIDTH-1:0]   update_target,
  input  logic                     update_predicted,
  output logic [31:0]              predict_count,
  output logic [31:0]              mispredict_count
);
  localparam int AW = `ADDR_WIDTH;
  localparam int TW = AW - INDEX_BITS - 1;
  localparam logic [`OP_CODE_BITS-1:0] BR_MASK = `OP_CODE_BITS'(6'b110000);
  localparam logic [`OP_CODE_BITS-1:0] JMP = `OP_CODE_BITS'(`OP_CODE_JMP);
  logic [ENTRIES-1:0] valid;
  logic [TW-1:0] tag [ENTRIES];
  logic [AW-1:0] target [ENTRIES];
  logic [1:0] ctr [ENTRIES];
  logic [INDEX_BITS-1:0] li, ui;
  logic [TW-1:0] lt, ut;
  logic l_hit, u_hit, is_cond;
  assign li = lookup_pc[INDEX_BITS:1];
  assign lt = lookup_pc[AW-1:INDEX_BITS+1];
  assign ui = update_pc[INDEX_BITS:1];
  assign ut = update_pc[AW-1:INDEX_BITS+1];
  assign l_hit = valid[li] && tag[li] == lt;
  assign u_hit = valid[ui] && tag[ui] == ut;
  assign is_cond = (lookup_opcode & BR_MASK) == BR_MASK && lookup_opcode != JMP;
  assign take_branch = is_cond && l_hit && ctr[li][1];
  assign branch_predict = l_hit ? target[li] : '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i] <= '0;
        target[i] <= '0;
        ctr[i] <= 2'd1;
      end
    end else if (update_valid) begin
      if (u_hit) begin
        ctr[ui] <= update_taken ? (ctr[ui] == 2'd3 ? 2'd3 : ctr[ui] + 2'd1)
                                : (ctr[ui] == 2'd0 ? 2'd0 : ctr[ui] - 2'd1);
        if (update_taken) target[ui] <= update_target;
      end else if (update_taken) begin
        valid[ui] <= 1'b1;
        tag[ui] <= ut;
        target[ui] <= update_target;
        ctr[ui] <= 2'd2;
      end
    end
  end
`ifdef BP_STATS_EN
  logic unused_bits;
  assign unused_bits = ^{lookup_pc[0], update_pc[0]};
  always_ff @(posedge clk) begin
    if (!reset) begin
      predict_count <= '0;
      mispredict_count <= '0;
    end else begin
      if (take_branch && predict_count != '1) predict_count <= predict_count + 32'd1;
      if (update_valid && update_predicted != update_taken && mispredict_count != '1)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{lookup_pc[0], update_pc[0], update_predicted};
  assign predict_count = '0;
  assign mispredict_count = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: table-driven scoreboard bench for branch_predictor
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef OP_CODE_BITS
`define OP_CODE_BITS 6
`endif
`ifndef OP_CODE_JMP
`define OP_CODE_JMP 6'b110000
`endif
module tb_branch_predictor;
  localparam int AW = `ADDR_WIDTH;
  localparam int OB = `OP_CODE_BITS;
  localparam logic [OB-1:0] BR = OB'(6'h31);
  localparam logic [OB-1:0] JMP = OB'(`OP_CODE_JMP);
  localparam logic [OB-1:0] NOP = OB'(6'h00);
  localparam logic [AW-1:0] PA = AW'(16'h0010);
  localparam logic [AW-1:0] PB = AW'(16'h0030);
  localparam logic [AW-1:0] PC2 = AW'(16'h0012);
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 0, take_branch, update_valid = 0, update_taken = 0, update_predicted = 0;
  logic [AW-1:0] lookup_pc = '0, branch_predict, update_pc = '0, update_target = '0;
  logic [OB-1:0] lookup_opcode = '0;
  logic [31:0] predict_count, mispredict_count;
  branch_predictor dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .lookup_opcode(lookup_opcode),
    .take_branch(take_branch), .branch_predict(branch_predict),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_predicted(update_predicted),
    .predict_count(predict_count), .mispredict_count(mispredict_count)
  );
  typedef struct {
    logic rst; logic [AW-1:0] lpc; logic [OB-1:0] lop;
    logic uv; logic [AW-1:0] upc; logic ut; logic [AW-1:0] utg; logic upr;
    logic et; logic [AW-1:0] ep;
  } vec_t;
  typedef struct { int id; logic t; logic [AW-1:0] p; } exp_t;
  exp_t sbq[$];
  int compared = 0, mismatched = 0;
  function automatic vec_t v(logic rst, logic [AW-1:0] lpc, logic [OB-1:0] lop, logic uv,
                             logic [AW-1:0] upc, logic ut, logic [AW-1:0] utg, logic upr,
                             logic et, logic [AW-1:0] ep);
    vec_t r;
    r.rst = rst; r.lpc = lpc; r.lop = lop; r.uv = uv; r.upc = upc; r.ut = ut;
    r.utg = utg; r.upr = upr; r.et = et; r.ep = ep;
    return r;
  endfunction
  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s #%0d: got %h, expected %h", name, id, act, exp);
    end
  endtask
  task automatic step(input vec_t x, input int id);
    exp_t e;
    @(posedge clk);
    #1;
    reset = x.rst; lookup_pc = x.lpc; lookup_opcode = x.lop; update_valid = x.uv;
    update_pc = x.upc; update_taken = x.ut; update_target = x.utg; update_predicted = x.upr;
    sbq.push_back('{id, x.et, x.ep});
    @(negedge clk);
    e = sbq.pop_front();
    check("take_branch", e.id, 32'(take_branch), 32'(e.t));
    check("branch_predict", e.id, 32'(branch_predict), 32'(e.p));
  endtask
  vec_t tbl[$];
  initial begin
    tbl.push_back(v(1, PA, BR, 0, PA, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, PA, BR, 1, PA, 1, 16'h40, 0, 0, 0));
    tbl.push_back(v(1, PA, BR, 0, 0, 0, 0, 0, 1, 16'h40));
    tbl.push_back(v(1, PA, NOP, 0, 0, 0, 0, 0, 0, 16'h40));
    tbl.push_back(v(1, PA, JMP, 0, 0, 0, 0, 0, 0, 16'h40));
    tbl.push_back(v(1, PA, BR, 1, PA, 0, 0, 0, 1, 16'h40));
    tbl.push_back(v(1, PA, BR, 1, PA, 0, 0, 0, 0, 16'h40));
    tbl.push_back(v(1, PA, BR, 1, PA, 0, 0, 0, 0, 16'h40));
    tbl.push_back(v(1, PA, BR, 1, PA, 1, 16'h44, 0, 0, 16'h40));
    tbl.push_back(v(1, PA, BR, 1, PA, 1, 16'h48, 0, 0, 16'h44));
    tbl.push_back(v(1, PA, BR, 1, PA, 1, 16'h48, 0, 1, 16'h48));
    tbl.push_back(v(1, PA, BR, 1, PA, 1, 16'h48, 0, 1, 16'h48));
    tbl.push_back(v(1, PA, BR, 1, PA, 0, 0, 0, 1, 16'h48));
    tbl.push_back(v(1, PA, BR, 1, PA, 0, 0, 0, 1, 16'h48));
    tbl.push_back(v(1, PA, BR, 0, 0, 0, 0, 0, 0, 16'h48));
    tbl.push_back(v(1, PB, BR, 1, PB, 1, 16'h80, 0, 0, 0));
    tbl.push_back(v(1, PA, BR, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, PB, BR, 0, 0, 0, 0, 0, 1, 16'h80));
    tbl.push_back(v(1, PB, JMP, 0, 0, 0, 0, 0, 0, 16'h80));
    tbl.push_back(v(1, PB, BR, 1, 16'h0050, 0, 0, 0, 1, 16'h80));
    tbl.push_back(v(1, PB, BR, 1, PC2, 1, 16'h100, 0, 1, 16'h80));
    tbl.push_back(v(1, 16'h0013, BR, 0, 0, 0, 0, 0, 1, 16'h100));
    tbl.push_back(v(0, PB, BR, 1, PB, 1, 16'h90, 0, 1, 16'h80));
    tbl.push_back(v(1, PB, BR, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, PC2, BR, 0, 0, 0, 0, 0, 0, 0));
    reset = 0;
    repeat (2) @(posedge clk);
    foreach (tbl[i]) step(tbl[i], i);
    step(v(0, PA, NOP, 0, 0, 0, 0, 0, 0, 0), 100);
    step(v(1, PA, NOP, 1, PA, 1, 16'h40, 1, 0, 0), 101);
    step(v(1, PA, BR, 1, PA, 1, 16'h40, 0, 1, 16'h40), 102);
    step(v(1, PA, BR, 1, PA, 1, 16'h40, 0, 1, 16'h40), 103);
    step(v(1, PA, BR, 0, 0, 0, 0, 0, 1, 16'h40), 104);
    step(v(1, PA, NOP, 0, 0, 0, 0, 0, 0, 16'h40), 105);
`ifdef BP_STATS_EN
    check("predict_count", 105, predict_count, 32'd3);
    check("mispredict_count", 105, mispredict_count, 32'd2);
`else
    check("predict_count", 105, predict_count, 32'd0);
    check("mispredict_count", 105, mispredict_count, 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Branch target buffer with 2-bit saturating direction counters that sits directly upstream of the program counter. Each cycle it looks up the PC of the instruction being steered and drives `take_branch` and `branch_predict` into the PC stage. It learns from resolved branches reported by the execute stage through a single update port. All widths come from `defines.vh` (`ADDR_WIDTH`, `OP_CODE_BITS`, `OP_CODE_JMP`).

## Interface
- `ENTRIES`, 16: number of BTB entries; must be a power of two, ≥2.
- `INDEX_BITS`, 4: log2(`ENTRIES`); must match `ENTRIES`.
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  one clock; reset is synchronous and active-low (`reset`==0 resets).
- `lookup_pc`  in  `ADDR_WIDTH`  address of the instruction being steered.
- `lookup_opcode`  in  `OP_CODE_BITS`  opcode of that instruction.
- `take_branch`  out  1  predict taken; to PC stage.
- `branch_predict`  out  `ADDR_WIDTH`  predicted target; to PC stage.
- `update_valid`  in  1  a conditional branch resolved this cycle.
- `update_pc`  in  `ADDR_WIDTH`  address of the resolved branch.
- `update_taken`  in  1  actual direction.
- `update_target`  in  `ADDR_WIDTH`  actual target (meaningful when taken).
- `update_predicted`  in  1  the `take_branch` value originally issued for this branch.
- `predict_count`  out  32  predictions made taken (see Configuration).
- `mispredict_count`  out  32  mispredicted resolutions (see Configuration).

## Operation
- Instructions are 2-byte aligned; `pc[0]` is ignored.
  - index = `pc[INDEX_BITS:1]`.
  - tag = `pc[ADDR_WIDTH-1:INDEX_BITS+1]`.
- Entry fields: valid (1), tag, target (`ADDR_WIDTH`), counter (2 bits; 0–1 not-taken, 2–3 taken).
- Conditional branch: `(opcode & 6'b110000) == 6'b110000` and `opcode != OP_CODE_JMP`.
- Lookup is combinational. Set `take_branch` = conditional branch & valid & tag match & counter[1]. Set `branch_predict` = entry target on hit, else 0.
- Update, on the clock edge when `update_valid` is high:
  - Hit, taken: counter = min(counter+1, 3); target = `update_target`.
  - Hit, not taken: counter = max(counter−1, 0); target unchanged.
  - Miss, taken: allocate (overwrite) the entry: valid=1, tag, target, counter=2.
  - Miss, not taken: no change.
- Only one update per cycle. There is no replacement policy beyond direct-mapped overwrite.
- `stall` and `flush` do not enter this block. Lookups are pure functions of table state, and updates are never squashed.

## Timing
- Lookup latency is 0 cycles: outputs are valid in the same cycle as `lookup_pc` and `lookup_opcode`.
- An update written at edge N is visible to lookups from cycle N+1. A lookup to the same entry in the update cycle sees old contents.
- Reset (`reset`==0 at an edge) does the following:
  - Clears all valid bits, sets counters to 1, targets to 0 and stat counters to 0.
  - Completes in that single edge.
  - Takes priority over a simultaneous update, which is dropped.
- After reset, `take_branch`=0 and `branch_predict`=0 for every lookup until the first taken update.
- Counters saturate at 0 and 3; there is no wrap.

## Configuration
- `BP_STATS_EN` defined:
  - `predict_count` increments on each edge where `take_branch`=1 and `reset`=1.
  - `mispredict_count` increments on each edge where `update_valid` & (`update_predicted` != `update_taken`) and `reset`=1.
  - Both saturate at 0xFFFFFFFF.
- `BP_STATS_EN` undefined: counter logic is not built; both ports are tied to 0.

## Test plan
- Reset, then look up pc=0x0010 with a conditional branch opcode → `take_branch`=0, `branch_predict`=0.
- Update pc=0x0010, taken, target=0x0040 (miss) → next cycle, lookup 0x0010 gives `take_branch`=1, `branch_predict`=0x0040 (counter=2).
- Two not-taken updates to 0x0010 → counter 2→1→0; lookup gives `take_branch`=0. A third not-taken update leaves the counter at 0. One taken update → counter 1, still not taken.
- Alias pc=0x0010 and pc=0x0030 (same index with `ENTRIES`=16, different tag):
  - Taken update to 0x0030 overwrites the entry.
  - Lookup 0x0010 → miss.
  - Lookup with opcode=`OP_CODE_JMP` at a hit address → `take_branch`=0.
- Assert `reset`=0 in the same cycle as a taken update → after the edge, all lookups miss and the update is not applied.
- With `BP_STATS_EN`: issue 3 hit lookups and 2 resolutions with `update_predicted`≠`update_taken` → `predict_count`=3, `mispredict_count`=2. Without the macro, both stay 0.
